// File: rtl/dmem_arbiter_if.sv
// Shared L1 data-memory bus: core port A, host port B and the memory command.
// The arbiter takes the slave view; requesters and the memory take master.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [3:0]            a_be;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [31:0]           a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [31:0]           b_wdata;
  logic [3:0]            b_be;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [31:0]           b_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic [31:0]           mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_be,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    input  mem_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_be,
    output b_req, b_we, b_addr, b_wdata, b_be,
    output mem_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared L1 data memory: core A has priority,
// host B wins after MAX_WAIT consecutive refusals. Read latency is one cycle.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_WAIT   = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rd_pending_q, rd_pending_d;
  logic          rd_owner_q, rd_owner_d;

  logic                  a_gnt, b_gnt;
  logic                  en, we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            be;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (bus.a_req && bus.b_req) begin
        b_gnt = (wait_cnt_q == WMAX);
        a_gnt = !b_gnt;
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end
  end

  always_comb begin
    en    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    unique case (1'b1)
      a_gnt: begin
        en    = 1'b1;
        we    = bus.a_we;
        addr  = bus.a_addr;
        wdata = bus.a_wdata;
        be    = bus.a_be;
      end
      b_gnt: begin
        en    = 1'b1;
        we    = bus.b_we;
        addr  = bus.b_addr;
        wdata = bus.b_wdata;
        be    = bus.b_be;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_d = '0;
    if (bus.b_req && !b_gnt)
      wait_cnt_d = (wait_cnt_q == WMAX) ? WMAX : wait_cnt_q + 1'b1;
    rd_pending_d = en && !we;
    rd_owner_d   = en ? b_gnt : rd_owner_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.mem_en    = en;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_be    = be;

  // rd_owner: 0 = A, 1 = B
  assign bus.a_rvalid = rd_pending_q && !rd_owner_q;
  assign bus.b_rvalid = rd_pending_q && rd_owner_q;
  assign bus.a_rdata  = bus.a_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.b_rdata  = bus.b_rvalid ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 13;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus();

  dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int refused = 0;
  bit pend    = 0;
  bit pend_b  = 0;

  function automatic logic [1:0] exp_gnt();
    if (reset) return 2'b00;
    if (bus.a_req && bus.b_req) return (refused >= MW) ? 2'b10 : 2'b01;
    return {bus.b_req, bus.a_req};
  endfunction

  task automatic step();
    logic [1:0] g;
    logic w;
    g = exp_gnt();
    w = g[1] ? bus.b_we : bus.a_we;
    pend   = (g != 2'b00) && !w;
    pend_b = g[1];
    if (bus.b_req && !g[1]) refused = (refused < MW) ? refused + 1 : MW;
    else refused = 0;
    @(posedge clk);
    @(negedge clk);
    bus.mem_rdata = $urandom;
  endtask

  task automatic set_a(bit req, bit we, logic [AW-1:0] addr,
                       logic [31:0] wd, logic [3:0] be);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr;
    bus.a_wdata = wd; bus.a_be = be;
  endtask

  task automatic set_b(bit req, bit we, logic [AW-1:0] addr,
                       logic [31:0] wd, logic [3:0] be);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr;
    bus.b_wdata = wd; bus.b_be = be;
  endtask

  task automatic idle();
    set_a(0, 0, '0, '0, '0);
    set_b(0, 0, '0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_a(1, 1, 13'h5, 32'h1, 4'hF);
    set_b(1, 0, 13'h6, 32'h2, 4'hF);
    #1;
    n_cmp++;
    if ({bus.b_gnt, bus.a_gnt} !== 2'b00) begin
      n_bad++; $display("FAIL reset_gnt got %b want 00", {bus.b_gnt, bus.a_gnt});
    end
    n_cmp++;
    if ({bus.mem_en, bus.mem_we} !== 2'b00) begin
      n_bad++; $display("FAIL reset_mem got %b want 00", {bus.mem_en, bus.mem_we});
    end
    n_cmp++;
    if ({bus.b_rvalid, bus.a_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL reset_rvalid got %b want 00", {bus.b_rvalid, bus.a_rvalid});
    end
    n_cmp++;
    if (dut.wait_cnt_q !== 3'd0) begin
      n_bad++; $display("FAIL reset_wait got %0d want 0", dut.wait_cnt_q);
    end
    @(negedge clk);
    reset = 1'b0;
    refused = 0; pend = 0;
    #1;
    n_cmp++;
    if ({bus.b_gnt, bus.a_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL resume_gnt got %b want 01", {bus.b_gnt, bus.a_gnt});
    end
    idle();
    step();
  endtask

  task automatic test_single_read();
    set_a(1, 0, 13'h010, 32'h0, 4'hF);
    #1;
    n_cmp++;
    if ({bus.b_gnt, bus.a_gnt, bus.mem_en, bus.mem_we, bus.mem_addr}
        !== {4'b0110, 13'h010}) begin
      n_bad++; $display("FAIL read_cmd gnt=%b%b en=%b we=%b addr=%h want 0110 010",
        bus.b_gnt, bus.a_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    step();
    bus.mem_rdata = 32'hDEADBEEF;
    idle();
    #1;
    n_cmp++;
    if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL read_data v=%b d=%h want 1 deadbeef", bus.a_rvalid, bus.a_rdata);
    end
    n_cmp++;
    if ({bus.b_rvalid, bus.b_rdata} !== 33'h0) begin
      n_bad++; $display("FAIL read_other v=%b d=%h want 0 0", bus.b_rvalid, bus.b_rdata);
    end
  endtask

  task automatic test_starvation();
    set_a(1, 0, 13'h100, '0, 4'hF);
    set_b(1, 0, 13'h200, '0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({bus.b_gnt, bus.a_gnt} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL starve_gnt[%0d] got %b", i, {bus.b_gnt, bus.a_gnt});
      end
      n_cmp++;
      if (int'(dut.wait_cnt_q) != i % 5) begin
        n_bad++; $display("FAIL starve_wait[%0d] got %0d want %0d", i, dut.wait_cnt_q, i % 5);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_write();
    set_a(1, 1, 13'h1FFF, 32'h00001234, 4'b0011);
    #1;
    n_cmp++;
    if ({bus.a_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}
        !== {3'b111, 4'b0011, 13'h1FFF, 32'h00001234}) begin
      n_bad++; $display("FAIL write_cmd g=%b en=%b we=%b be=%b a=%h d=%h",
        bus.a_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({bus.b_rvalid, bus.a_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL write_rvalid got %b want 00", {bus.b_rvalid, bus.a_rvalid});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    set_a(1, 0, 13'h020, '0, 4'hF);
    #1;
    n_cmp++;
    if (bus.a_gnt !== 1'b1) begin
      n_bad++; $display("FAIL b2b_a_gnt got %b want 1", bus.a_gnt);
    end
    step();
    d0 = bus.mem_rdata;
    set_a(0, 0, '0, '0, '0);
    set_b(1, 0, 13'h030, '0, 4'hF);
    #1;
    n_cmp++;
    if ({bus.a_rvalid, bus.a_rdata, bus.b_gnt, bus.mem_addr}
        !== {1'b1, d0, 1'b1, 13'h030}) begin
      n_bad++; $display("FAIL b2b_c1 av=%b ad=%h bg=%b a=%h want 1 %h 1 030",
        bus.a_rvalid, bus.a_rdata, bus.b_gnt, bus.mem_addr, d0);
    end
    step();
    d1 = bus.mem_rdata;
    idle();
    #1;
    n_cmp++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.b_rdata} !== {2'b01, d1}) begin
      n_bad++; $display("FAIL b2b_c2 av=%b bv=%b bd=%h want 0 1 %h",
        bus.a_rvalid, bus.b_rvalid, bus.b_rdata, d1);
    end
    step();
  endtask

  task automatic test_reset_drop();
    set_a(1, 0, 13'h044, '0, 4'hF);
    set_b(1, 0, 13'h055, '0, 4'hF);
    step();
    reset = 1'b1;
    idle();
    #1;
    n_cmp++;
    if ({bus.b_rvalid, bus.a_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL drop_rvalid_in_rst got %b want 00", {bus.b_rvalid, bus.a_rvalid});
    end
    n_cmp++;
    if (dut.wait_cnt_q !== 3'd0) begin
      n_bad++; $display("FAIL drop_wait got %0d want 0", dut.wait_cnt_q);
    end
    @(negedge clk);
    reset = 1'b0;
    refused = 0; pend = 0;
    #1;
    n_cmp++;
    if ({bus.b_rvalid, bus.a_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL drop_rvalid_after got %b want 00", {bus.b_rvalid, bus.a_rvalid});
    end
    step();
  endtask

  task automatic test_b_drop();
    set_a(1, 0, 13'h070, '0, 4'hF);
    set_b(1, 1, 13'h080, 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.b_gnt, bus.a_gnt} !== 2'b01) begin
        n_bad++; $display("FAIL bdrop_pre[%0d] got %b want 01", i, {bus.b_gnt, bus.a_gnt});
      end
      step();
    end
    bus.b_req = 1'b0;
    #1;
    n_cmp++;
    if (dut.wait_cnt_q !== 3'd3) begin
      n_bad++; $display("FAIL bdrop_wait3 got %0d want 3", dut.wait_cnt_q);
    end
    step();
    bus.b_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({bus.b_gnt, bus.a_gnt} !== ((i == 4) ? 2'b10 : 2'b01) ||
          int'(dut.wait_cnt_q) != i) begin
        n_bad++; $display("FAIL bdrop_post[%0d] gnt=%b wait=%0d want wait %0d",
          i, {bus.b_gnt, bus.a_gnt}, dut.wait_cnt_q, i);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_random();
    logic [1:0] g;
    for (int i = 0; i < 400; i++) begin
      #1;
      g = exp_gnt();
      n_cmp++;
      if ({bus.b_gnt, bus.a_gnt, bus.mem_en} !== {g, |g}) begin
        n_bad++; $display("FAIL rnd_gnt[%0d] got %b%b en=%b want %b",
          i, bus.b_gnt, bus.a_gnt, bus.mem_en, g);
      end
      n_cmp++;
      if (g[1] && {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}
          !== {bus.b_we, bus.b_addr, bus.b_wdata, bus.b_be} ||
          g[0] && {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}
          !== {bus.a_we, bus.a_addr, bus.a_wdata, bus.a_be} ||
          g == 2'b00 && {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
        n_bad++; $display("FAIL rnd_cmd[%0d] we=%b a=%h d=%h be=%b",
          i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
      n_cmp++;
      if ({bus.b_rvalid, bus.a_rvalid, bus.b_rdata, bus.a_rdata} !==
          {pend && pend_b, pend && !pend_b,
           (pend && pend_b) ? bus.mem_rdata : 32'h0,
           (pend && !pend_b) ? bus.mem_rdata : 32'h0}) begin
        n_bad++; $display("FAIL rnd_rsp[%0d] bv=%b av=%b bd=%h ad=%h pend=%b owner_b=%b",
          i, bus.b_rvalid, bus.a_rvalid, bus.b_rdata, bus.a_rdata, pend, pend_b);
      end
      step();
      if (!(bus.a_req && !g[0]))
        set_a($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom),
              $urandom, 4'($urandom));
      if (!(bus.b_req && !g[1]))
        set_b($urandom_range(0, 2) == 0, $urandom_range(0, 1), AW'($urandom),
              $urandom, 4'($urandom));
    end
    idle();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_starvation();
    test_write();
    test_back_to_back();
    test_reset_drop();
    test_b_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, meaning the word address width of the shared L1 memory.
REQ-002 The block SHALL have parameter MAX_WAIT, default 4, meaning the number of cycles port B may be refused before it takes priority.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have ports a_req, b_req, input, 1 each, meaning an access request from core (A) or host (B).
REQ-006 The block SHALL have ports a_we, b_we, input, 1 each, meaning write (1) or read (0).
REQ-007 The block SHALL have ports a_addr, b_addr, input, ADDR_WIDTH each, meaning the word address.
REQ-008 The block SHALL have ports a_wdata, b_wdata, input, 32 each, meaning the write data.
REQ-009 The block SHALL have ports a_be, b_be, input, 4 each, meaning the byte enables.
REQ-010 The block SHALL have ports a_gnt, b_gnt, output, 1 each, meaning the request is accepted this cycle.
REQ-011 The block SHALL have ports a_rvalid, b_rvalid, output, 1 each, meaning read data is valid this cycle.
REQ-012 The block SHALL have ports a_rdata, b_rdata, output, 32 each, meaning the read data.
REQ-013 The block SHALL have ports mem_en, mem_we, output, 1 each; mem_addr, output, ADDR_WIDTH; mem_wdata, output, 32; and mem_be, output, 4, meaning the memory command.
REQ-014 The block SHALL have port mem_rdata, input, 32, meaning memory read data valid one cycle after mem_en with mem_we=0.

Function
REQ-015 Arbitration SHALL be combinational within the cycle, and at most one of a_gnt and b_gnt SHALL be high in any cycle.
REQ-016 When only one port requests, that port SHALL be granted in the same cycle.
REQ-017 When both ports request and wait_cnt < MAX_WAIT, A SHALL be granted.
REQ-018 When both ports request and wait_cnt == MAX_WAIT, B SHALL be granted.
REQ-019 wait_cnt SHALL be a counter of width clog2(MAX_WAIT+1).
  - It SHALL increment when b_req is high and b_gnt is low, saturating at MAX_WAIT.
  - It SHALL clear to 0 on b_gnt or when b_req is low.
REQ-020 In a granted cycle, mem_en SHALL be 1 and mem_we, mem_addr, mem_wdata and mem_be SHALL mirror the granted port; otherwise mem_en and mem_we SHALL be 0 and the other memory outputs SHALL hold 0.
REQ-021 For a granted read, the block SHALL register rd_pending=1 and rd_owner=A/B.
  - In the next cycle, the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata.
  - The other port's rvalid SHALL be 0.
REQ-022 Granted writes SHALL NOT produce rvalid.
REQ-023 Back-to-back grants SHALL be supported each cycle (throughput 1 access per cycle, read latency 1), including A-read then B-read, where a_rvalid and b_gnt are high in the same cycle.
REQ-024 Outside rvalid, a_rdata and b_rdata SHALL be 0.
REQ-025 A requester SHALL hold its request and payload stable until granted; the block SHALL NOT buffer refused requests.

Reset
REQ-026 While reset is high, wait_cnt=0, rd_pending=0 and rd_owner=A SHALL hold, and all rvalid outputs SHALL be 0, asynchronously.
REQ-027 While reset is high, a_gnt, b_gnt, mem_en and mem_we SHALL be forced to 0 regardless of requests.
REQ-028 A read granted in the cycle before reset asserts SHALL be dropped: no rvalid after reset deasserts.
REQ-029 Arbitration SHALL resume on the first rising edge with reset low.

Verification
REQ-030 A bench SHALL cover: single A read at addr 0x010 with mem_rdata=0xDEADBEEF -> a_gnt in cycle 0, a_rvalid=1 and a_rdata=0xDEADBEEF in cycle 1, b_rvalid=0.
REQ-031 A bench SHALL cover: both ports requesting continuously, MAX_WAIT=4 -> grants A,A,A,A,B repeating, with wait_cnt counting 0..4.
REQ-032 A bench SHALL cover: A write at addr 0x1FFF, be=4'b0011, wdata=0x00001234 -> mem_en=1, mem_we=1, mem_be=0011, mem_addr=0x1FFF, and no rvalid afterward.
REQ-033 A bench SHALL cover: A read then B read on consecutive cycles -> a_rvalid and b_gnt in cycle 1, b_rvalid in cycle 2, each with the correct data.
REQ-034 A bench SHALL cover: read granted, then reset pulsed in the next cycle -> no rvalid observed, and wait_cnt=0 after reset.
REQ-035 A bench SHALL cover: b_req dropped after 3 refusals, then reasserted -> wait_cnt restarts from 0 and A keeps priority for 4 more cycles.
